vram_writer: RTL and testbench



---
 rtl/vram_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_vram_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - CPU write side of the tile VRAM: request FIFO plus direct/RMW commit FSM
//
// Purpose:
//   Accepts CPU store requests and buffers them in a small FIFO. Each request
//   is committed to the VRAM write port as a whole 32-bit word.
//   - A word store with all four byte strobes set is written directly.
//   - A word store with a partial strobe, and every single-tile (2-bit) store,
//     uses read-modify-write through the VRAM read port.
//   Out-of-range requests are dropped and set a sticky error flag.
//
// Configuration macro:
//   VRAM_WRITER_VBLANK_GATE_EN - when defined, entries leave the FIFO only
//   while vblank = 1. When undefined, vblank is ignored.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (req_ready = FIFO not full)
//   req_mode               0 = word store, 1 = tile store
//   req_addr               word address (mode 0) or tile index (mode 1)
//   req_wdata, req_wstrb   store data / byte enables (tile store uses wdata[1:0])
//   vblank                 scanout outside visible area
//   vram_re, vram_raddr    VRAM read strobe / word address
//   vram_rdata             VRAM read data, valid the cycle after vram_re
//   vram_we, vram_waddr,
//   vram_wdata             VRAM write strobe / word address / data
//   busy                   FIFO non-empty or a commit in progress
//   err, err_clr           sticky out-of-range flag and its clear
module vram_writer #(
  parameter int TILES_H    = 25,
  parameter int TILES_V    = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        vblank,
  output logic        vram_re,
  output logic [4:0]  vram_raddr,
  input  logic [31:0] vram_rdata,
  output logic        vram_we,
  output logic [4:0]  vram_waddr,
  output logic [31:0] vram_wdata,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  localparam int TILES_TOTAL = TILES_H * TILES_V;
  localparam int VRAM_SIZE   = (TILES_TOTAL + 15) / 16;
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int EW          = 1 + 9 + 32 + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    MRG  = 2'd2,
    WR   = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // Request FIFO. Pointers carry one extra wrap bit so full and empty
  // are distinguishable when the index bits match.
  // ------------------------------------------------------------------
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // req_ready depends only on registered pointers, so a pop in this cycle
  // cannot make room for a push in the same cycle.
  assign req_ready = !full;
  assign push      = req_valid && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {req_mode, req_addr, req_wdata, req_wstrb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Head-of-FIFO decode and range check
  // ------------------------------------------------------------------
  logic        h_mode;
  logic [8:0]  h_addr;
  logic [31:0] h_data;
  logic [3:0]  h_strb;
  logic [4:0]  h_word;
  logic        h_in_range;

  assign {h_mode, h_addr, h_data, h_strb} = fifo_mem[rd_ptr[AW-1:0]];
  assign h_word     = h_mode ? h_addr[8:4] : h_addr[4:0];
  assign h_in_range = h_mode ? (h_addr < 9'(TILES_TOTAL)) : (h_addr < 9'(VRAM_SIZE));

  // ------------------------------------------------------------------
  // Commit gate
  // ------------------------------------------------------------------
  logic gate_open;
`ifdef VRAM_WRITER_VBLANK_GATE_EN
  assign gate_open = vblank;
`else
  logic  unused_vblank;
  assign gate_open     = 1'b1;
  assign unused_vblank = vblank;
`endif

  // ------------------------------------------------------------------
  // Commit FSM
  // ------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   load;
  logic   set_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    set_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && gate_open) begin
          pop = 1'b1;
          if (!h_in_range) begin
            set_err = 1'b1;
          end else if (!h_mode && (h_strb == 4'h0)) begin
            // Empty strobe: nothing to write, silently dropped.
          end else begin
            load    = 1'b1;
            state_d = (!h_mode && (h_strb == 4'hF)) ? WR : RD;
          end
        end
      end
      RD:      state_d = MRG;
      MRG:     state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath: the popped entry is held until its write is done
  // ------------------------------------------------------------------
  logic        cur_mode;
  logic [4:0]  cur_word;
  logic [3:0]  cur_pair;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;
  logic [31:0] wdata_q;
  logic [31:0] merged;
  logic [4:0]  tile_shift;
  logic [31:0] tile_mask;

  assign tile_shift = {cur_pair, 1'b0};
  assign tile_mask  = 32'h3 << tile_shift;

  always_comb begin
    merged = vram_rdata;
    if (cur_mode) begin
      merged = (vram_rdata & ~tile_mask) | ((32'(cur_data[1:0]) << tile_shift) & tile_mask);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (cur_strb[b]) merged[b*8 +: 8] = cur_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_mode <= 1'b0;
      cur_word <= '0;
      cur_pair <= '0;
      cur_data <= '0;
      cur_strb <= '0;
      wdata_q  <= '0;
    end else if (load) begin
      cur_mode <= h_mode;
      cur_word <= h_word;
      cur_pair <= h_addr[3:0];
      cur_data <= h_data;
      cur_strb <= h_strb;
      // Full-strobe stores go straight to WR with this value.
      wdata_q  <= h_data;
    end else if (state_q == MRG) begin
      wdata_q  <= merged;
    end
  end

  // Sticky error; a clear in the same cycle as a new error wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_clr) err <= 1'b0;
    else if (set_err) err <= 1'b1;
  end

  assign vram_re    = (state_q == RD);
  assign vram_we    = (state_q == WR);
  assign vram_raddr = cur_word;
  assign vram_waddr = cur_word;
  assign vram_wdata = wdata_q;
  assign busy       = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_vram_writer.sv
// tb/tb_vram_writer.sv - directed self-checking bench for vram_writer
module tb_vram_writer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_mode;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        vblank;
  logic        vram_re;
  logic [4:0]  vram_raddr;
  logic [31:0] vram_rdata;
  logic        vram_we;
  logic [4:0]  vram_waddr;
  logic [31:0] vram_wdata;
  logic        busy;
  logic        err;
  logic        err_clr;

  vram_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .vblank     (vblank),
    .vram_re    (vram_re),
    .vram_raddr (vram_raddr),
    .vram_rdata (vram_rdata),
    .vram_we    (vram_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          re_cnt = 0;
  int          we_cyc = 0;
  int          push_cyc = 0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] mem [32];

  // VRAM model: synchronous read port, write port, write/read monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (vram_re) vram_rdata <= mem[vram_raddr];
    if (rst_n && vram_we) begin
      mem[vram_waddr] <= vram_wdata;
      we_cnt          <= we_cnt + 1;
      we_cyc          <= cyc + 1;
      last_waddr      <= vram_waddr;
      last_wdata      <= vram_wdata;
    end
    if (rst_n && vram_re) re_cnt <= re_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("push_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_mode  = m;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    @(posedge clk); #1;
    push_cyc  = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  int e0;
  int r0;
  int n;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    vram_rdata = 32'h0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    vblank    = 1'b1;
    err_clr   = 1'b0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_vram_re", 32'(vram_re), 32'd0);
    chk("rst_vram_we", 32'(vram_we), 32'd0);
    chk("rst_raddr", 32'(vram_raddr), 32'd0);
    chk("rst_waddr", 32'(vram_waddr), 32'd0);
    chk("rst_wdata", vram_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-strobe word store: direct write, 2 cycles after push, no read.
    r0 = re_cnt;
    push(1'b0, 9'd3, 32'hDEADBEEF, 4'hF);
    wait_idle();
    chk("direct_latency", 32'(we_cyc - push_cyc), 32'd2);
    chk("direct_waddr", 32'(last_waddr), 32'd3);
    chk("direct_wdata", last_wdata, 32'hDEADBEEF);
    chk("direct_no_read", 32'(re_cnt - r0), 32'd0);

    // Tile stores into word 0 preloaded with 0x1B1B1B1B.
    push(1'b0, 9'd0, 32'h1B1B1B1B, 4'hF);
    wait_idle();
    r0 = re_cnt;
    push(1'b1, 9'd5, 32'h2, 4'h0);
    wait_idle();
    chk("tile_latency", 32'(we_cyc - push_cyc), 32'd4);
    chk("tile_one_read", 32'(re_cnt - r0), 32'd1);
    chk("tile_waddr", 32'(last_waddr), 32'd0);
    chk("tile_wdata_10", last_wdata, 32'h1B1B1B1B);
    push(1'b1, 9'd5, 32'hFFFFFFFD, 4'h0);
    wait_idle();
    chk("tile_wdata_01", last_wdata, 32'h1B1B171B);

    // Partial strobe, issued back-to-back behind the preload of word 2.
    push(1'b0, 9'd2, 32'h11223344, 4'hF);
    push(1'b0, 9'd2, 32'hAABBCCDD, 4'b0101);
    wait_idle();
    chk("strobe_wdata", last_wdata, 32'h11BB33DD);
    chk("strobe_mem", mem[2], 32'h11BB33DD);

    // Out-of-range requests.
    e0 = we_cnt;
    push(1'b1, 9'd450, 32'h3, 4'h0);
    wait_idle();
    chk("tile450_err", 32'(err), 32'd1);
    chk("tile450_no_write", 32'(we_cnt - e0), 32'd0);
    pulse_clr();
    chk("err_cleared", 32'(err), 32'd0);
    push(1'b0, 9'd29, 32'h12345678, 4'hF);
    wait_idle();
    chk("word29_err", 32'(err), 32'd1);
    chk("word29_no_write", 32'(we_cnt - e0), 32'd0);
    // Clear held across a new error: clear must win.
    err_clr = 1'b1;
    push(1'b1, 9'd500, 32'h1, 4'h0);
    wait_idle();
    err_clr = 1'b0;
    chk("clr_wins", 32'(err), 32'd0);
    // Zero strobe: dropped without error.
    push(1'b0, 9'd1, 32'hFFFFFFFF, 4'h0);
    wait_idle();
    chk("zero_strb_no_err", 32'(err), 32'd0);
    chk("zero_strb_no_write", 32'(we_cnt - e0), 32'd0);

    // Last valid tile index lands in word 28, bits [3:2].
    push(1'b1, 9'd449, 32'h3, 4'h0);
    wait_idle();
    chk("tile449_waddr", 32'(last_waddr), 32'd28);
    chk("tile449_wdata", last_wdata, 32'h0000000C);
    chk("tile449_err", 32'(err), 32'd0);

    // Five back-to-back RMW stores into word 4 fill the FIFO; every
    // read must see the previous write.
    e0 = we_cnt;
    push(1'b1, 9'd64, 32'h3, 4'h0);
    push(1'b1, 9'd65, 32'h3, 4'h0);
    push(1'b1, 9'd66, 32'h3, 4'h0);
    push(1'b1, 9'd67, 32'h3, 4'h0);
    push(1'b1, 9'd68, 32'h3, 4'h0);
    chk("fifo_full_ready", 32'(req_ready), 32'd0);
    wait_idle();
    chk("fifo_writes", 32'(we_cnt - e0), 32'd5);
    chk("fifo_coherent", mem[4], 32'h000003FF);
    chk("fifo_ready_back", 32'(req_ready), 32'd1);

`ifdef VRAM_WRITER_VBLANK_GATE_EN
    // Gate closed: requests buffer, ready drops at 4, nothing written.
    vblank = 1'b0;
    e0 = we_cnt;
    push(1'b0, 9'd5, 32'h00000001, 4'hF);
    push(1'b0, 9'd5, 32'h00000002, 4'hF);
    push(1'b0, 9'd6, 32'h00000003, 4'hF);
    push(1'b0, 9'd7, 32'h00000004, 4'hF);
    chk("gate_ready_low", 32'(req_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("gate_no_write", 32'(we_cnt - e0), 32'd0);
    vblank = 1'b1;
    push(1'b0, 9'd5, 32'h00000005, 4'b0010);
    wait_idle();
    chk("gate_writes", 32'(we_cnt - e0), 32'd5);
    chk("gate_word5", mem[5], 32'h00000002);
    chk("gate_word7", mem[7], 32'h00000004);
    chk("gate_ready_back", 32'(req_ready), 32'd1);
`endif

    // Reset during MRG abandons the write.
    push(1'b1, 9'd0, 32'h1, 4'h0);
    n = 0;
    while (!vram_re && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mrg_saw_read", 32'(vram_re), 32'd1);
    @(posedge clk); #1;
    e0 = we_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(vram_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_no_write", 32'(we_cnt - e0), 32'd0);
    chk("rst_mid_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
